pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the next-generation embedded CPU.
//  Replaces the fixed increment-only PC with several capabilities:
//  - jump, conditional branch and conditional skip
//  - call/return through a hardware return-address stack of configurable depth
//  - halt/resume state machine with fault trapping on stack overflow/underflow
//  Sits between instruction decode (op/target/cond) and program memory (pc_out).
// PARAMETERS
//  PC_W       5   PC width; program space is 2**PC_W words
//  STACK_D    4   return-stack depth in entries (>=1)
//  RESET_VEC  0   PC value loaded on reset
// PORTS
//  clk          in   1                    system clock, rising edge
//  n_reset      in   1                    synchronous reset, active low
//  stall        in   1                    1: hold all state this cycle
//  resume       in   1                    leave HALTED state (ignored in RUN)
//  op           in   3                    seq_op_t: NEXT,JUMP,BRANCH,CALL,RET,SKIP,HALT
//  target       in   PC_W                 jump/branch/call destination
//  cond         in   1                    condition for BRANCH and SKIP
//  pc_out       out  PC_W                 current instruction address
//  depth        out  $clog2(STACK_D+1)    entries currently on stack
//  halted       out  1                    1 when state is HALTED
//  overflow     out  1                    sticky: CALL attempted on full stack
//  underflow    out  1                    sticky: RET attempted on empty stack
// BEHAVIOUR
//  Reset
//  - One clock; reset is synchronous and active-low (n_reset sampled on the rising clk edge).
//  - On reset: pc_out=RESET_VEC, depth=0, halted=0, overflow=0, underflow=0, state=RUN.
//  - Reset overrides stall, resume and op, including in the middle of a call sequence.
//  Timing
//  - All outputs are registered.
//  - An op presented in cycle k takes effect in pc_out/depth after edge k+1.
//  - Latency is one cycle; there are no combinational paths from inputs to outputs.
//  Stall
//  - stall=1 holds pc, stack, depth, state and flags. op is ignored and no push/pop occurs.
//  - stall has priority over every op and over resume.
//  RUN state, per op (pc arithmetic is mod 2**PC_W, so 2**PC_W-1 +1 wraps to 0)
//  - NEXT:   pc <= pc+1
//  - JUMP:   pc <= target
//  - BRANCH: pc <= cond ? target : pc+1
//  - SKIP:   pc <= cond ? pc+2 : pc+1
//  - CALL, depth<STACK_D: push pc+1, then pc <= target, depth++
//  - CALL, depth==STACK_D: no push, pc held, overflow<=1, state<=HALTED
//  - RET, depth>0: pc <= top of stack, pop, depth--
//  - RET, depth==0: pc held, underflow<=1, state<=HALTED
//  - HALT: pc held, state<=HALTED
//  HALTED state
//  - pc, stack and depth are held and op is ignored.
//  - resume=1 (with stall=0): state<=RUN and pc <= pc+1. The faulting or HALT instruction is not re-executed.
//  Flags and undefined ops
//  - overflow and underflow clear only on reset. resume does not clear them.
//  - Undefined op encodings behave as NEXT.
//  Stack
//  - LIFO. Entries above depth are don't-care.
//  - Push and pop never occur in the same cycle.
// STRUCTURE
//  Package cpu_seq_pkg
//  - typedef enum logic[2:0] seq_op_t {NEXT=0,JUMP,BRANCH,CALL,RET,SKIP,HALT}
//  - typedef enum logic seq_state_t {RUN,HALTED}
//  Sub-module ret_stack #(W=PC_W,D=STACK_D)
//  - ports: clk, n_reset, push, pop, din, dout(top), depth, full, empty
//  - pc_sequencer owns the FSM, next-PC mux and flags.
// TESTING
//  T1 reset: n_reset=0 for one edge -> pc_out=0, depth=0, halted=0, overflow=0, underflow=0
//  T2 NEXT x3 from reset -> pc_out 1,2,3; then CALL target=10 -> pc_out=10, depth=1; RET -> pc_out=4, depth=0
//  T3 with STACK_D=4, five CALLs (targets 8,9,10,11,12) -> after the 4th pc=11, depth=4; 5th -> pc=11, overflow=1, halted=1
//  T4 RET at depth=0 -> underflow=1, halted=1, pc held; resume -> halted=0, pc+1; underflow stays 1
//  T5 wrap: JUMP 31 then NEXT -> pc_out=0; JUMP 30 then SKIP cond=1 -> 0; BRANCH cond=0 at 0 -> 1
//  T6 stall=1 with CALL target=20 for 3 cycles -> pc, depth unchanged; release -> pc=20, depth=1; reset mid-sequence -> T1 values

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types for the program-counter sequencer: decode ops and FSM states.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        NEXT   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        SKIP   = 3'd5,
        HALT   = 3'd6
    } seq_op_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; dout is the current top entry, zero when empty.
module ret_stack #(
    parameter int unsigned W = 5,
    parameter int unsigned D = 4
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(D+1)-1:0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned DW = $clog2(D + 1);
    localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = AW'(depth);
    assign rd_idx = AW'(depth - DW'(1));
    assign full   = (depth == DW'(D));
    assign empty  = (depth == '0);
    assign dout   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            depth <= '0;
        end else if (push) begin
            depth <= depth + DW'(1);
        end else if (pop) begin
            depth <= depth - DW'(1);
        end
    end

    // Storage is not reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (n_reset && push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, call/return stack control and
// a RUN/HALTED state machine that traps on stack overflow and underflow.
module pc_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned     PC_W      = 5,
    parameter int unsigned     STACK_D   = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           stall,
    input  logic                           resume,
    input  logic [2:0]                     op,
    input  logic [PC_W-1:0]                target,
    input  logic                           cond,
    output logic [PC_W-1:0]                pc_out,
    output logic [$clog2(STACK_D+1)-1:0]   depth,
    output logic                           halted,
    output logic                           overflow,
    output logic                           underflow
);

    seq_state_t      state;
    seq_op_t         op_e;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_inc2;
    logic [PC_W-1:0] stack_top;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            run_go;

    assign op_e    = seq_op_t'(op);
    assign pc_inc  = pc_out + PC_W'(1);
    assign pc_inc2 = pc_out + PC_W'(2);

    // Stack strobes must be decided in the same cycle as the PC update.
    always_comb begin
        run_go = n_reset && !stall && (state == RUN);
        push   = run_go && (op_e == CALL) && !full;
        pop    = run_go && (op_e == RET) && !empty;
    end

    ret_stack #(
        .W (PC_W),
        .D (STACK_D)
    ) u_stack (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .dout    (stack_top),
        .depth   (depth),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= RUN;
            pc_out    <= RESET_VEC;
            halted    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall) begin
            if (state == HALTED) begin
                if (resume) begin
                    state  <= RUN;
                    halted <= 1'b0;
                    pc_out <= pc_inc;
                end
            end else begin
                case (op_e)
                    JUMP:   pc_out <= target;
                    BRANCH: pc_out <= cond ? target : pc_inc;
                    SKIP:   pc_out <= cond ? pc_inc2 : pc_inc;
                    CALL: begin
                        if (full) begin
                            overflow <= 1'b1;
                            state    <= HALTED;
                            halted   <= 1'b1;
                        end else begin
                            pc_out <= target;
                        end
                    end
                    RET: begin
                        if (empty) begin
                            underflow <= 1'b1;
                            state     <= HALTED;
                            halted    <= 1'b1;
                        end else begin
                            pc_out <= stack_top;
                        end
                    end
                    HALT: begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                    default: pc_out <= pc_inc;
                endcase
            end
        end
    end

endmodule
